// File: rtl/fetch_prefetch_if.sv
// Fetch/prefetch bus bundle: instruction-memory req/ack channel, redirect
// input from execute and the decode-side show-ahead queue head.
//   master : the fetch unit (drives imem_req/addr, dec_valid/instr/pc, occupancy)
//   slave  : memory + execute + decode environment
interface fetch_prefetch_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [XLEN-1:0]   redirect_target;
    logic              dec_valid;
    logic              dec_ready;
    logic [31:0]       dec_instr;
    logic [XLEN-1:0]   dec_pc;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_target,
        output dec_valid, dec_instr, dec_pc, occupancy,
        input  dec_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_target,
        input  dec_valid, dec_instr, dec_pc, occupancy,
        output dec_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with a DEPTH-entry show-ahead prefetch queue.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_prefetch_if.master:
//          imem_req/imem_addr (registered, held until imem_ack),
//          imem_ack/imem_rdata (response), redirect/redirect_target (flush),
//          dec_valid/dec_ready/dec_instr/dec_pc (queue head), occupancy.
// One request is outstanding at most. A redirect with no ack pending moves
// to DROP so the stale response is swallowed before the new fetch starts.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ADDR_W   = 10,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst_n,
    fetch_prefetch_if.master  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   req_pc, req_pc_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              req_q;

    logic [31:0]       instr_q [DEPTH];
    logic [XLEN-1:0]   pc_q    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, post_cnt;

    logic              head_valid, pop, push, space, flush;
    logic [XLEN-1:0]   target;

    assign target     = bus.redirect_target & ~XLEN'(3);
    assign flush      = bus.redirect;
    assign head_valid = (count != '0);
    assign pop        = head_valid & bus.dec_ready;
    assign space      = (count < CNT_W'(DEPTH)) | pop;
    // Count after this cycle's push, with a same-cycle pop credited.
    assign post_cnt   = count + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_n  = state;
        req_pc_n = req_pc;
        push     = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    req_pc_n = target;
                    state_n  = REQ;
                end else if (space) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    // With ack the response is dropped and the new fetch
                    // goes out next cycle; without ack we must wait it out.
                    req_pc_n = target;
                    state_n  = bus.imem_ack ? REQ : DROP;
                end else if (bus.imem_ack) begin
                    push     = 1'b1;
                    req_pc_n = req_pc + XLEN'(4);
                    state_n  = (post_cnt < CNT_W'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                // req_pc already holds the pending target; newest redirect wins.
                if (flush)        req_pc_n = target;
                if (bus.imem_ack) state_n  = REQ;
            end
            default: state_n = IDLE;
        endcase
        // In DROP the bus must keep presenting the stale address until ack.
        addr_n = (state_n == DROP) ? addr_q : req_pc_n[ADDR_W+1:2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            req_pc <= RESET_PC;
            addr_q <= RESET_PC[ADDR_W+1:2];
            req_q  <= 1'b0;
        end else begin
            state  <= state_n;
            req_pc <= req_pc_n;
            addr_q <= addr_n;
            req_q  <= (state_n != IDLE);
        end
    end

    // Queue control. Flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_rdata;
            pc_q[wr_ptr]    <= req_pc;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.dec_valid = head_valid;
    assign bus.dec_instr = head_valid ? instr_q[rd_ptr] : '0;
    assign bus.dec_pc    = head_valid ? pc_q[rd_ptr]    : '0;
    assign bus.occupancy = count;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_prefetch_if #(.XLEN(32), .ADDR_W(10), .DEPTH(4)) bus ();
    fetch_prefetch_if #(.XLEN(32), .ADDR_W(10), .DEPTH(4)) bus2 ();

    fetch_prefetch_unit #(.XLEN(32), .ADDR_W(10), .DEPTH(4), .RESET_PC(32'h0))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fetch_prefetch_unit #(.XLEN(32), .ADDR_W(10), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int passed = 0;
    int total  = 0;

    // Stimulus variables for dut
    bit          mem_en = 1'b0;
    int          lat = 1;
    logic        resp_ack = 1'b0, man_ack = 1'b0;
    logic [31:0] resp_rdata = '0, man_rdata = '0;
    logic        redirect = 1'b0, dec_ready = 1'b0;
    logic [31:0] target = '0;

    assign bus.imem_ack        = mem_en ? resp_ack : man_ack;
    assign bus.imem_rdata      = mem_en ? resp_rdata : man_rdata;
    assign bus.redirect        = redirect;
    assign bus.redirect_target = target;
    assign bus.dec_ready       = dec_ready;

    // Stimulus variables for dut2 (wrap-around instance)
    logic        ack2 = 1'b0, ready2 = 1'b0;
    logic [31:0] rdata2 = '0;
    assign bus2.imem_ack        = ack2;
    assign bus2.imem_rdata      = rdata2;
    assign bus2.redirect        = 1'b0;
    assign bus2.redirect_target = '0;
    assign bus2.dec_ready       = ready2;

    // Memory contents: a unique word per word address.
    function automatic logic [31:0] instr_of(input logic [9:0] a);
        return {8'hA5, 4'h0, a, ~a};
    endfunction

    // Memory model: ack after `lat` cycles of an observed request.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (!rst_n || !mem_en) cnt = 0;
            else if (bus.imem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    resp_ack   = 1'b1;
                    resp_rdata = instr_of(bus.imem_addr);
                    cnt        = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", bus.imem_req); else passed++;
        total++; if (bus.imem_addr !== 10'h000) $display("FAIL reset_addr got %h exp 000", bus.imem_addr); else passed++;
        total++; if (bus.dec_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.dec_valid); else passed++;
        total++; if (bus.dec_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", bus.dec_instr); else passed++;
        total++; if (bus.dec_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", bus.dec_pc); else passed++;
        total++; if (bus.occupancy !== 3'd0) $display("FAIL reset_occ got %0d exp 0", bus.occupancy); else passed++;
        total++; if (bus2.imem_addr !== 10'h3FE) $display("FAIL reset_addr2 got %h exp 3fe", bus2.imem_addr); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [9:0] w;
        mem_en = 1'b1; lat = 1; dec_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            w = 10'(k - 1);
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== w)
                $display("FAIL stream_req k=%0d got %b/%h exp 1/%h", k, bus.imem_req, bus.imem_addr, w); else passed++;
            if (k == 1) begin
                total++; if (bus.dec_valid !== 1'b0) $display("FAIL stream_startup got %b exp 0", bus.dec_valid); else passed++;
            end else begin
                w = 10'(k - 2);
                total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'(4 * (k - 2)) || bus.dec_instr !== instr_of(w))
                    $display("FAIL stream_head k=%0d got %b/%h/%h exp 1/%h/%h", k, bus.dec_valid, bus.dec_pc,
                             bus.dec_instr, 32'(4 * (k - 2)), instr_of(w)); else passed++;
            end
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit idle_seen;
        mem_en = 1'b1; lat = 3; dec_ready = 1'b0;
        do_reset();
        idle_seen = 1'b0;
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            @(negedge clk);
            if (bus.occupancy == 3'd4 && bus.imem_req == 1'b0) idle_seen = 1'b1;
        end
        total++; if (!idle_seen) $display("FAIL bp_fill timeout occ=%0d req=%b exp occ=4 req=0", bus.occupancy, bus.imem_req); else passed++;
        @(negedge clk);
        total++; if (bus.occupancy !== 3'd4 || bus.imem_req !== 1'b0) $display("FAIL bp_hold got occ=%0d req=%b exp 4/0", bus.occupancy, bus.imem_req); else passed++;
        total++; if (bus.dec_pc !== 32'h0 || bus.dec_instr !== instr_of(10'd0)) $display("FAIL bp_head got %h/%h exp 0/%h", bus.dec_pc, bus.dec_instr, instr_of(10'd0)); else passed++;
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        total++; if (bus.occupancy !== 3'd3 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd4 || bus.dec_pc !== 32'h4)
            $display("FAIL bp_pop got occ=%0d req=%b addr=%h pc=%h exp 3/1/004/4", bus.occupancy, bus.imem_req, bus.imem_addr, bus.dec_pc); else passed++;
        repeat (3) @(negedge clk);
        total++; if (bus.occupancy !== 3'd4 || bus.imem_req !== 1'b0) $display("FAIL bp_refill got occ=%0d req=%b exp 4/0", bus.occupancy, bus.imem_req); else passed++;
    endtask

    task automatic test_redirect_pending();
        mem_en = 1'b0; man_ack = 1'b0; dec_ready = 1'b1;
        do_reset();
        @(negedge clk);
        redirect = 1'b1; target = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h0 || bus.dec_valid !== 1'b0)
            $display("FAIL rp_drop got req=%b addr=%h v=%b exp 1/000/0", bus.imem_req, bus.imem_addr, bus.dec_valid); else passed++;
        @(negedge clk);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        man_ack = 1'b0;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h10 || bus.dec_valid !== 1'b0)
            $display("FAIL rp_newreq got req=%b addr=%h v=%b exp 1/010/0", bus.imem_req, bus.imem_addr, bus.dec_valid); else passed++;
        @(negedge clk);
        man_ack = 1'b1; man_rdata = 32'h1234_5678;
        @(negedge clk);
        man_ack = 1'b0;
        total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h40 || bus.dec_instr !== 32'h1234_5678)
            $display("FAIL rp_first got v=%b pc=%h instr=%h exp 1/40/12345678", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
        dec_ready = 1'b0;
    endtask

    task automatic test_redirect_ack_pop();
        mem_en = 1'b0; man_ack = 1'b0; dec_ready = 1'b0;
        do_reset();
        @(negedge clk); man_ack = 1'b1; man_rdata = 32'hAAAA_0000;
        @(negedge clk); man_ack = 1'b1; man_rdata = 32'hAAAA_0001;
        @(negedge clk);
        total++; if (bus.occupancy !== 3'd2) $display("FAIL rap_pre got occ=%0d exp 2", bus.occupancy); else passed++;
        man_ack = 1'b1; man_rdata = 32'hAAAA_0002; dec_ready = 1'b1; redirect = 1'b1; target = 32'h103;
        @(negedge clk);
        man_ack = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
        total++; if (bus.occupancy !== 3'd0 || bus.dec_valid !== 1'b0) $display("FAIL rap_flush got occ=%0d v=%b exp 0/0", bus.occupancy, bus.dec_valid); else passed++;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h40) $display("FAIL rap_req got %b/%h exp 1/040", bus.imem_req, bus.imem_addr); else passed++;
        man_ack = 1'b1; man_rdata = 32'h3333_0001;
        @(negedge clk);
        man_ack = 1'b0;
        total++; if (bus.dec_pc !== 32'h100 || bus.dec_instr !== 32'h3333_0001 || bus.occupancy !== 3'd1)
            $display("FAIL rap_first got pc=%h instr=%h occ=%0d exp 100/33330001/1", bus.dec_pc, bus.dec_instr, bus.occupancy); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] epc;
        ack2 = 1'b0; ready2 = 1'b1;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            epc = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
            total++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== epc[11:2])
                $display("FAIL wrap_addr k=%0d got %b/%h exp 1/%h", k, bus2.imem_req, bus2.imem_addr, epc[11:2]); else passed++;
            if (k >= 2) begin
                epc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
                total++; if (bus2.dec_valid !== 1'b1 || bus2.dec_pc !== epc || bus2.dec_instr !== instr_of(epc[11:2]))
                    $display("FAIL wrap_pc k=%0d got %b/%h/%h exp 1/%h", k, bus2.dec_valid, bus2.dec_pc, bus2.dec_instr, epc); else passed++;
            end
            ack2 = bus2.imem_req; rdata2 = instr_of(bus2.imem_addr);
        end
        @(negedge clk);
        ack2 = 1'b0; ready2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b0; man_ack = 1'b0; dec_ready = 1'b0;
        do_reset();
        @(negedge clk); man_ack = 1'b1; man_rdata = 32'h1111_0000;
        @(negedge clk); man_ack = 1'b0;
        total++; if (bus.dec_valid !== 1'b1 || bus.imem_req !== 1'b1) $display("FAIL rm_pre got v=%b req=%b exp 1/1", bus.dec_valid, bus.imem_req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 10'h0 || bus.dec_valid !== 1'b0 || bus.dec_pc !== 32'h0 ||
                     bus.dec_instr !== 32'h0 || bus.occupancy !== 3'd0)
            $display("FAIL rm_async got req=%b addr=%h v=%b pc=%h instr=%h occ=%0d exp all zero", bus.imem_req, bus.imem_addr,
                     bus.dec_valid, bus.dec_pc, bus.dec_instr, bus.occupancy); else passed++;
        @(negedge clk);
        rst_n = 1'b1; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (bus.occupancy !== 3'd0 || bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h0)
            $display("FAIL rm_late_ack got occ=%0d v=%b req=%b addr=%h exp 0/0/1/000", bus.occupancy, bus.dec_valid, bus.imem_req, bus.imem_addr); else passed++;
        man_ack = 1'b1; man_rdata = 32'h2222_0000;
        @(negedge clk);
        man_ack = 1'b0;
        total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0 || bus.dec_instr !== 32'h2222_0000)
            $display("FAIL rm_first got v=%b pc=%h instr=%h exp 1/0/22220000", bus.dec_valid, bus.dec_pc, bus.dec_instr); else passed++;
    endtask

    // Random redirects, back-pressure and latency. Reference: the decode side
    // must see a contiguous +4 PC stream restarting at each redirect target,
    // each word equal to memory contents at that PC.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        prev_req, prev_ack;
        logic [9:0]  prev_addr;
        int          pops;
        mem_en = 1'b1; lat = 1; dec_ready = 1'b0; redirect = 1'b0;
        do_reset();
        exp_pc = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_req && !prev_ack) begin
                total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr)
                    $display("FAIL rnd_hold cyc=%0d got %b/%h exp 1/%h", cyc, bus.imem_req, bus.imem_addr, prev_addr); else passed++;
            end
            total++; if (bus.occupancy > 3'd4 || bus.dec_valid !== (bus.occupancy != 3'd0))
                $display("FAIL rnd_occ cyc=%0d got occ=%0d v=%b", cyc, bus.occupancy, bus.dec_valid); else passed++;
            if (cyc % 50 == 0) lat = $urandom_range(1, 4);
            redirect  = ($urandom_range(0, 24) == 0);
            target    = $urandom;
            dec_ready = ($urandom_range(0, 3) < (((cyc / 150) % 2) != 0 ? 3 : 1));
            if (redirect) exp_pc = target & ~32'h3;
            else if (bus.dec_valid && dec_ready) begin
                total++; if (bus.dec_pc !== exp_pc || bus.dec_instr !== instr_of(exp_pc[11:2]))
                    $display("FAIL rnd_pop cyc=%0d got %h/%h exp %h/%h", cyc, bus.dec_pc, bus.dec_instr, exp_pc, instr_of(exp_pc[11:2])); else passed++;
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
            #1;
            prev_req = bus.imem_req; prev_ack = bus.imem_ack; prev_addr = bus.imem_addr;
        end
        redirect = 1'b0; dec_ready = 1'b0;
        total++; if (pops < 200) $display("FAIL rnd_progress got %0d pops exp >= 200", pops); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_pending();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
